// File: rtl/pcpi_issue_ctrl.sv
// PCPI initiator: turns RV32M commands into a pcpi_valid/insn/rs1/rs2 request and
// returns result, write flag, error and occupancy count on a valid/ready response port.
module pcpi_issue_ctrl #(
    parameter int unsigned CLAIM_TIMEOUT = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_funct3,
    input  logic [4:0]       cmd_rs1_idx,
    input  logic [4:0]       cmd_rs2_idx,
    input  logic [4:0]       cmd_rd_idx,
    input  logic [31:0]      cmd_rs1,
    input  logic [31:0]      cmd_rs2,
    output logic             pcpi_valid,
    output logic [31:0]      pcpi_insn,
    output logic [31:0]      pcpi_rs1,
    output logic [31:0]      pcpi_rs2,
    input  logic             pcpi_wr,
    input  logic [31:0]      pcpi_rd,
    input  logic             pcpi_wait,
    input  logic             pcpi_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_wr,
    output logic             rsp_err,
    output logic [CNT_W-1:0] rsp_cycles
);

    localparam int unsigned CLAIM_W = $clog2(CLAIM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               pcpi_valid_q, pcpi_valid_d;
    logic [31:0]        pcpi_insn_q, pcpi_insn_d;
    logic [31:0]        pcpi_rs1_q, pcpi_rs1_d;
    logic [31:0]        pcpi_rs2_q, pcpi_rs2_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               rsp_wr_q, rsp_wr_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   rsp_cycles_q, rsp_cycles_d;
    logic [CLAIM_W-1:0] claim_cnt_q, claim_cnt_d;
    logic               claimed_q, claimed_d;
    logic               claimed_now;

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        pcpi_valid_d = pcpi_valid_q;
        pcpi_insn_d  = pcpi_insn_q;
        pcpi_rs1_d   = pcpi_rs1_q;
        pcpi_rs2_d   = pcpi_rs2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_wr_d     = rsp_wr_q;
        rsp_err_d    = rsp_err_q;
        rsp_cycles_d = rsp_cycles_q;
        claim_cnt_d  = claim_cnt_q;
        claimed_d    = claimed_q;
        claimed_now  = claimed_q | pcpi_wait;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    state_d      = ST_ISSUE;
                    cmd_ready_d  = 1'b0;
                    pcpi_valid_d = 1'b1;
                    pcpi_insn_d  = {7'b0000001, cmd_rs2_idx, cmd_rs1_idx, cmd_funct3,
                                    cmd_rd_idx, 7'b0110011};
                    pcpi_rs1_d   = cmd_rs1;
                    pcpi_rs2_d   = cmd_rs2;
                    rsp_cycles_d = '0;
                    claim_cnt_d  = '0;
                    claimed_d    = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (rsp_cycles_q != {CNT_W{1'b1}}) begin
                    rsp_cycles_d = rsp_cycles_q + CNT_W'(1);
                end
                claimed_d = claimed_now;
                if (!claimed_now) begin
                    claim_cnt_d = claim_cnt_q + CLAIM_W'(1);
                end
                // A result on the timeout edge still wins over the error
                if (pcpi_ready) begin
                    state_d      = ST_RESP;
                    pcpi_valid_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = pcpi_rd;
                    rsp_wr_d     = pcpi_wr;
                    rsp_err_d    = 1'b0;
                end else if (!claimed_now &&
                             (32'(claim_cnt_q) + 32'd1 >= 32'(CLAIM_TIMEOUT))) begin
                    state_d      = ST_RESP;
                    pcpi_valid_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = 32'd0;
                    rsp_wr_d     = 1'b0;
                    rsp_err_d    = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b0;
            pcpi_valid_q <= 1'b0;
            pcpi_insn_q  <= 32'd0;
            pcpi_rs1_q   <= 32'd0;
            pcpi_rs2_q   <= 32'd0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 32'd0;
            rsp_wr_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_cycles_q <= '0;
            claim_cnt_q  <= '0;
            claimed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            pcpi_valid_q <= pcpi_valid_d;
            pcpi_insn_q  <= pcpi_insn_d;
            pcpi_rs1_q   <= pcpi_rs1_d;
            pcpi_rs2_q   <= pcpi_rs2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_wr_q     <= rsp_wr_d;
            rsp_err_q    <= rsp_err_d;
            rsp_cycles_q <= rsp_cycles_d;
            claim_cnt_q  <= claim_cnt_d;
            claimed_q    <= claimed_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign pcpi_valid = pcpi_valid_q;
    assign pcpi_insn  = pcpi_insn_q;
    assign pcpi_rs1   = pcpi_rs1_q;
    assign pcpi_rs2   = pcpi_rs2_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_wr     = rsp_wr_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_cycles = rsp_cycles_q;

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// Directed bench for pcpi_issue_ctrl with an in-bench multiply responder stub.
module tb_pcpi_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_funct3;
    logic [4:0]  cmd_rs1_idx;
    logic [4:0]  cmd_rs2_idx;
    logic [4:0]  cmd_rd_idx;
    logic [31:0] cmd_rs1;
    logic [31:0] cmd_rs2;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_wr;
    logic        rsp_err;
    logic [15:0] rsp_cycles;

    int n_checks;
    int n_pass;

    pcpi_issue_ctrl #(.CLAIM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct3(cmd_funct3),
        .cmd_rs1_idx(cmd_rs1_idx), .cmd_rs2_idx(cmd_rs2_idx), .cmd_rd_idx(cmd_rd_idx),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1),
        .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_wr(rsp_wr), .rsp_err(rsp_err), .rsp_cycles(rsp_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Responder stub result for MUL/MULH/MULHSU/MULHU
    function automatic logic [31:0] mul_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        logic signed [64:0] psu;
        ps  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        pu  = {32'd0, a} * {32'd0, b};
        psu = $signed({{33{a[31]}}, a}) * $signed({33'd0, b});
        case (f3)
            3'b000:  return ps[31:0];
            3'b001:  return ps[63:32];
            3'b010:  return psu[63:32];
            3'b011:  return pu[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic wait_cmd_ready();
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    task automatic send_cmd(input logic [2:0] f3, input logic [4:0] i1, input logic [4:0] i2,
                            input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        wait_cmd_ready();
        cmd_valid   = 1'b1;
        cmd_funct3  = f3;
        cmd_rs1_idx = i1;
        cmd_rs2_idx = i2;
        cmd_rd_idx  = rd;
        cmd_rs1     = a;
        cmd_rs2     = b;
        tick();
        cmd_valid = 1'b0;
        cmd_rs1   = 32'hDEAD_BEEF;
        cmd_rs2   = 32'hDEAD_BEEF;
    endtask

    // wait_at/ready_at are 1-based ISSUE cycles (0 = never)
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [4:0] i1,
                          input logic [4:0] i2, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b,
                          input int wait_at, input int ready_at, input logic wr_drv,
                          input int hold, input logic [31:0] exp_insn,
                          input logic [31:0] exp_data, input logic exp_wr,
                          input logic exp_err, input int exp_cycles);
        int          vcnt;
        logic [31:0] d0;
        send_cmd(f3, i1, i2, rd, a, b);
        check({tag, "_rs1"}, pcpi_rs1, a);
        check({tag, "_rs2"}, pcpi_rs2, b);
        vcnt = 0;
        for (int k = 1; k <= 200; k++) begin
            if (pcpi_valid !== 1'b1) break;
            vcnt++;
            check({tag, "_insn"}, pcpi_insn, exp_insn);
            check({tag, "_cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
            pcpi_wait  = (wait_at > 0 && k >= wait_at);
            pcpi_ready = (k == ready_at);
            pcpi_wr    = wr_drv;
            pcpi_rd    = mul_model(pcpi_insn[14:12], pcpi_rs1, pcpi_rs2);
            tick();
            pcpi_wait  = 1'b0;
            pcpi_ready = 1'b0;
            pcpi_rd    = 32'h5A5A_5A5A;
        end
        check({tag, "_valid_cycles"}, 32'(vcnt), 32'(exp_cycles));
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_data"}, rsp_data, exp_data);
        check({tag, "_rsp_wr"}, 32'(rsp_wr), 32'(exp_wr));
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, "_rsp_cycles"}, 32'(rsp_cycles), 32'(exp_cycles));
        d0 = rsp_data;
        for (int h = 0; h < hold; h++) begin
            pcpi_ready = 1'b1;
            tick();
            pcpi_ready = 1'b0;
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_data"}, rsp_data, d0);
            check({tag, "_hold_cycles"}, 32'(rsp_cycles), 32'(exp_cycles));
            check({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
            check({tag, "_hold_pcpi_valid"}, 32'(pcpi_valid), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle_pcpi_valid"}, 32'(pcpi_valid), 32'd0);
        check({tag, "_idle_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_funct3  = 3'd0;
        cmd_rs1_idx = 5'd0;
        cmd_rs2_idx = 5'd0;
        cmd_rd_idx  = 5'd0;
        cmd_rs1     = 32'd0;
        cmd_rs2     = 32'd0;
        pcpi_wr     = 1'b0;
        pcpi_rd     = 32'd0;
        pcpi_wait   = 1'b0;
        pcpi_ready  = 1'b0;
        rsp_ready   = 1'b0;

        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_pcpi_valid", 32'(pcpi_valid), 32'd0);
        check("rst_insn", pcpi_insn, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_cycles", 32'(rsp_cycles), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // MUL 3*7, ready on 4th ISSUE cycle
        run_op("mul", 3'b000, 5'd1, 5'd2, 5'd3, 32'd3, 32'd7, 0, 4, 1'b1, 0,
               32'h022081B3, 32'd21, 1'b1, 1'b0, 4);
        // MULHU all-ones squared
        run_op("mulhu", 3'b011, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2, 1'b1, 0,
               32'h0220B1B3, 32'hFFFF_FFFE, 1'b1, 1'b0, 2);
        // MULH -10 * -4 = 40, high word 0
        run_op("mulh", 3'b001, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFF6, 32'hFFFF_FFFC, 0, 3, 1'b1, 0,
               32'h022091B3, 32'd0, 1'b1, 1'b0, 3);
        // Insn encoding, zero-wait responder, no write
        run_op("insn", 3'b001, 5'd5, 5'd6, 5'd7, 32'd2, 32'd3, 0, 1, 1'b0, 0,
               32'h026293B3, 32'd0, 1'b0, 1'b0, 1);
        // No responder: claim timeout after 16 cycles
        run_op("timeout", 3'b000, 5'd1, 5'd2, 5'd3, 32'd9, 32'd9, 0, 0, 1'b1, 0,
               32'h022081B3, 32'd0, 1'b0, 1'b1, 16);
        // Claimed at cycle 2, slow result at cycle 40, response back-pressured 5 cycles
        run_op("slow", 3'b000, 5'd1, 5'd2, 5'd3, 32'd100, 32'd5, 2, 40, 1'b1, 5,
               32'h022081B3, 32'd500, 1'b1, 1'b0, 40);

        // Reset in the middle of ISSUE drops the op
        send_cmd(3'b000, 5'd1, 5'd2, 5'd3, 32'd4, 32'd4);
        pcpi_wait = 1'b1;
        tick();
        tick();
        check("mid_pcpi_valid", 32'(pcpi_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        pcpi_wait = 1'b0;
        check("midrst_pcpi_valid", 32'(pcpi_valid), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("midrst_rsp_cycles", 32'(rsp_cycles), 32'd0);
        pcpi_ready = 1'b1;
        pcpi_rd    = 32'h1234_5678;
        pcpi_wr    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_ignore_rsp_valid", 32'(rsp_valid), 32'd0);
            check("idle_ignore_pcpi_valid", 32'(pcpi_valid), 32'd0);
        end
        pcpi_ready = 1'b0;
        check("idle_ignore_rsp_data", rsp_data, 32'd0);

        // Recovery after reset
        run_op("recover", 3'b000, 5'd1, 5'd2, 5'd3, 32'd6, 32'd7, 1, 2, 1'b1, 1,
               32'h022081B3, 32'd42, 1'b1, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
